// File: rtl/mem_writeback.sv
// mem_writeback: retire stage behind execute.
// ALU/jump results go straight to the register file; loads and stores run a
// single req/ack data-memory transaction, with stall_out held while busy.
//
// state  | meaning
// IDLE   | accepting instructions; ALU writeback and misaligned pulses issue here
// ACCESS | dmem_req held, waiting for dmem_ack or the timeout limit
// WB     | load data being written to the register file (rf_we high)
module mem_writeback #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        req,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WB     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        stall_q, stall_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_error_q, bus_error_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [4:0]  rd_q, rd_d;

  logic        is_alu, is_load, is_store;
  logic        load_ok, store_ok;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [31:0] rdata_shifted;
  logic [31:0] load_value;
  logic        tmo_hit;

  // Opcode decode and alignment / funct3 legality of the incoming instruction.
  always_comb begin
    is_alu   = (opcode_in == OP_REG) || (opcode_in == OP_IMM) ||
               (opcode_in == OP_LUI) || (opcode_in == OP_AUIPC) ||
               (opcode_in == OP_JAL) || (opcode_in == OP_JALR);
    is_load  = (opcode_in == OP_LOAD);
    is_store = (opcode_in == OP_STORE);

    // Undefined funct3 encodings fall into the misaligned path.
    case (funct3_in)
      3'b000, 3'b100: load_ok = 1'b1;
      3'b001, 3'b101: load_ok = ~result_in[0];
      3'b010:         load_ok = (result_in[1:0] == 2'b00);
      default:        load_ok = 1'b0;
    endcase

    case (funct3_in)
      3'b000:  store_ok = 1'b1;
      3'b001:  store_ok = ~result_in[0];
      3'b010:  store_ok = (result_in[1:0] == 2'b00);
      default: store_ok = 1'b0;
    endcase
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = rs2_value_in;
    case (funct3_in)
      3'b000: begin
        store_be    = 4'b0001 << result_in[1:0];
        store_wdata = {4{rs2_value_in[7:0]}};
      end
      3'b001: begin
        store_be    = 4'b0011 << result_in[1:0];
        store_wdata = {2{rs2_value_in[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = rs2_value_in;
      end
    endcase
  end

  // Lane select and sign/zero extension of returning load data.
  always_comb begin
    rdata_shifted = dmem_rdata >> {addr_lo_q, 3'b000};
    case (funct3_q)
      3'b000:  load_value = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_value = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_value = {24'd0, rdata_shifted[7:0]};
      3'b101:  load_value = {16'd0, rdata_shifted[15:0]};
      default: load_value = dmem_rdata;
    endcase
  end

  // Timeout fires on the cycle the count would reach the limit; zero disables it.
  always_comb begin
    tmo_hit = (TIMEOUT_CYCLES != 0) && ((tmo_cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;
    tmo_cnt_d    = tmo_cnt_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    rd_d         = rd_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if (is_alu) begin
            rf_we_d    = (rd_in != 5'd0);
            rf_waddr_d = rd_in;
            rf_wdata_d = result_in;
          end else if (is_load || is_store) begin
            if ((is_load && load_ok) || (is_store && store_ok)) begin
              state_d      = ST_ACCESS;
              dmem_req_d   = 1'b1;
              dmem_we_d    = is_store;
              dmem_addr_d  = {result_in[31:2], 2'b00};
              dmem_wdata_d = is_store ? store_wdata : 32'd0;
              dmem_be_d    = is_store ? store_be : 4'b1111;
              tmo_cnt_d    = 32'd0;
              funct3_d     = funct3_in;
              addr_lo_d    = result_in[1:0];
              rd_d         = rd_in;
            end else begin
              misaligned_d = 1'b1;
            end
          end
        end
      end

      ST_ACCESS: begin
        if (dmem_ack || tmo_hit) begin
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_addr_d  = 32'd0;
          dmem_wdata_d = 32'd0;
          dmem_be_d    = 4'b0000;
          tmo_cnt_d    = 32'd0;
          if (dmem_ack) begin
            if (dmem_we_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d    = ST_WB;
              rf_we_d    = (rd_q != 5'd0);
              rf_waddr_d = rd_q;
              rf_wdata_d = load_value;
            end
          end else begin
            state_d     = ST_IDLE;
            bus_error_d = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end

      ST_WB: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    stall_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears everything and abandons any access.
  always_ff @(posedge req or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      dmem_be_q    <= 4'b0000;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= 32'd0;
      stall_q      <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      tmo_cnt_q    <= 32'd0;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      rd_q         <= 5'd0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      stall_q      <= stall_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
      tmo_cnt_q    <= tmo_cnt_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      rd_q         <= rd_d;
    end
  end

  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign dmem_be        = dmem_be_q;
  assign rf_we          = rf_we_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign stall_out      = stall_q;
  assign misaligned_out = misaligned_q;
  assign bus_error_out  = bus_error_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: directed cases followed by random instructions
// checked against a behavioural model of the retire rules.
module tb_mem_writeback;

  logic        req = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [6:0]  opcode_in = '0;
  logic [2:0]  funct3_in = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] result_in = '0;
  logic [31:0] rs2_value_in = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_out, misaligned_out, bus_error_out;

  int n_pass = 0;
  int n_total = 0;

  mem_writeback #(.TIMEOUT_CYCLES(16)) dut (
    .req(req), .reset(reset), .valid_in(valid_in), .opcode_in(opcode_in),
    .funct3_in(funct3_in), .rd_in(rd_in), .result_in(result_in),
    .rs2_value_in(rs2_value_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall_out(stall_out),
    .misaligned_out(misaligned_out), .bus_error_out(bus_error_out)
  );

  always #5 req = ~req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Access size in bytes for a load/store funct3; 0 means undefined encoding.
  function automatic int access_size(input bit is_ld, input logic [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd4: return is_ld ? 1 : 0;
      3'd5: return is_ld ? 2 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int lane, input logic [31:0] w);
    logic [31:0] s, b, h;
    s = w >> (8 * lane);
    b = s % 256;
    h = s % 65536;
    case (f3)
      3'd0: return (b >= 128) ? b - 32'd256 : b;
      3'd1: return (h >= 32768) ? h - 32'd65536 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  // Issue one instruction from IDLE and follow it back to IDLE.
  // dly = ACCESS cycles without ack before the ack cycle; dly >= 16 never acks.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] res, input logic [31:0] rs2,
                           input int dly, input logic [31:0] rdata);
    bit is_ld, is_st, is_alu, ok, done;
    int size, lane;
    logic [31:0] e_be, e_wd, e_addr;
    is_ld  = (op == 7'b0000011);
    is_st  = (op == 7'b0100011);
    is_alu = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0110111) ||
             (op == 7'b0010111) || (op == 7'b1101111) || (op == 7'b1100111);
    lane   = int'(res[1:0]);
    size   = access_size(is_ld, f3);
    ok     = (size != 0) && (lane % size == 0);
    e_addr = res - 32'(lane);
    e_be   = 32'd15;
    e_wd   = rs2;
    if (is_st && size == 1) begin e_be = 32'd1 << lane; e_wd = (rs2 % 256) * 32'h0101_0101; end
    if (is_st && size == 2) begin e_be = 32'd3 << lane; e_wd = (rs2 % 65536) * 32'h0001_0001; end

    @(negedge req);
    valid_in = 1'b1; opcode_in = op; funct3_in = f3; rd_in = rd;
    result_in = res; rs2_value_in = rs2;
    @(negedge req);
    valid_in = 1'b0;

    if (!(is_ld || is_st)) begin
      chk("alu_rf_we", 32'(rf_we), 32'(is_alu && rd != 0));
      if (is_alu && rd != 0) begin
        chk("alu_waddr", 32'(rf_waddr), 32'(rd));
        chk("alu_wdata", rf_wdata, res);
      end
      chk("alu_stall", 32'(stall_out), 32'd0);
      chk("alu_no_req", 32'(dmem_req), 32'd0);
      @(negedge req);
      chk("alu_we_pulse", 32'(rf_we), 32'd0);
    end else if (!ok) begin
      chk("mis_pulse", 32'(misaligned_out), 32'd1);
      chk("mis_no_req", 32'(dmem_req), 32'd0);
      chk("mis_no_we", 32'(rf_we), 32'd0);
      chk("mis_stall", 32'(stall_out), 32'd0);
      @(negedge req);
      chk("mis_pulse_end", 32'(misaligned_out), 32'd0);
      chk("mis_no_req2", 32'(dmem_req), 32'd0);
    end else begin
      done = 1'b0;
      for (int k = 1; k <= 16 && !done; k++) begin
        chk("acc_req", 32'(dmem_req), 32'd1);
        chk("acc_stall", 32'(stall_out), 32'd1);
        chk("acc_we", 32'(dmem_we), 32'(is_st));
        chk("acc_addr", dmem_addr, e_addr);
        chk("acc_be", 32'(dmem_be), e_be);
        if (is_st) chk("acc_wdata", dmem_wdata, e_wd);
        chk("acc_no_rf", 32'(rf_we), 32'd0);
        // Upstream traffic during a stall must be ignored.
        valid_in = 1'($urandom_range(0, 1));
        opcode_in = 7'b0010011; rd_in = 5'd1; result_in = $urandom;
        if (k == dly + 1) begin
          dmem_ack = 1'b1; dmem_rdata = rdata; done = 1'b1;
        end else begin
          dmem_rdata = $urandom;
        end
        @(negedge req);
      end
      valid_in = 1'b0; dmem_ack = 1'b0;
      if (done && is_ld) begin
        chk("ld_rf_we", 32'(rf_we), 32'(rd != 0));
        if (rd != 0) begin
          chk("ld_waddr", 32'(rf_waddr), 32'(rd));
          chk("ld_wdata", rf_wdata, model_load(f3, lane, rdata));
        end
        chk("ld_req_drop", 32'(dmem_req), 32'd0);
        chk("ld_wb_stall", 32'(stall_out), 32'd1);
        @(negedge req);
        chk("ld_we_pulse", 32'(rf_we), 32'd0);
        chk("ld_idle", 32'(stall_out), 32'd0);
      end else if (done) begin
        chk("st_req_drop", 32'(dmem_req), 32'd0);
        chk("st_idle", 32'(stall_out), 32'd0);
        chk("st_no_rf", 32'(rf_we), 32'd0);
        chk("st_no_berr", 32'(bus_error_out), 32'd0);
      end else begin
        chk("tmo_berr", 32'(bus_error_out), 32'd1);
        chk("tmo_req_drop", 32'(dmem_req), 32'd0);
        chk("tmo_idle", 32'(stall_out), 32'd0);
        chk("tmo_no_rf", 32'(rf_we), 32'd0);
        @(negedge req);
        chk("tmo_berr_pulse", 32'(bus_error_out), 32'd0);
      end
    end
  endtask

  logic [6:0] alu_ops [6] = '{7'b0110011, 7'b0010011, 7'b0110111,
                              7'b0010111, 7'b1101111, 7'b1100111};

  initial begin
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_mis", 32'(misaligned_out), 32'd0);
    chk("rst_berr", 32'(bus_error_out), 32'd0);
    @(negedge req);
    reset = 1'b0;

    run_instr(7'b0010011, 3'd0, 5'd5, 32'h0000_002A, 32'd0, 0, 32'd0);        // ADDI
    run_instr(7'b0000011, 3'd0, 5'd9, 32'h0000_1003, 32'd0, 2, 32'h80FF_0000); // LB
    run_instr(7'b0100011, 3'd1, 5'd0, 32'h0000_2002, 32'h1234_ABCD, 1, 32'd0); // SH
    run_instr(7'b0000011, 3'd2, 5'd3, 32'h0000_3001, 32'd0, 0, 32'd0);         // LW misaligned
    run_instr(7'b0000011, 3'd2, 5'd4, 32'h0000_3000, 32'd0, 16, 32'd0);        // LW timeout
    run_instr(7'b0000011, 3'd2, 5'd6, 32'h0000_3004, 32'd0, 15, 32'hCAFE_F00D);// ack at limit
    run_instr(7'b0000011, 3'd2, 5'd0, 32'h0000_3008, 32'd0, 0, 32'h1111_2222); // LW rd=0
    run_instr(7'b1100011, 3'd0, 5'd7, 32'h0000_0040, 32'd0, 0, 32'd0);         // branch

    // Stray ack while idle has no effect.
    @(negedge req);
    dmem_ack = 1'b1;
    @(negedge req);
    dmem_ack = 1'b0;
    chk("stray_ack_stall", 32'(stall_out), 32'd0);
    chk("stray_ack_rf", 32'(rf_we), 32'd0);
    chk("stray_ack_req", 32'(dmem_req), 32'd0);

    // Reset in the middle of an access.
    @(negedge req);
    valid_in = 1'b1; opcode_in = 7'b0000011; funct3_in = 3'd2; rd_in = 5'd7;
    result_in = 32'h0000_4000;
    @(negedge req);
    valid_in = 1'b0;
    chk("mid_req_before", 32'(dmem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall_out), 32'd0);
    @(negedge req);
    reset = 1'b0;
    @(negedge req);
    chk("mid_rst_discard_rf", 32'(rf_we), 32'd0);
    chk("mid_rst_idle", 32'(stall_out), 32'd0);

    for (int i = 0; i < 60; i++) begin
      int sel, d;
      logic [6:0] op;
      sel = $urandom_range(0, 13);
      if (sel <= 5) op = alu_ops[sel];
      else if (sel == 6) op = 7'b1100011;
      else if (sel == 7) op = 7'b1110011;
      else if (sel == 8) op = 7'b1111111;
      else if (sel <= 10) op = 7'b0000011;
      else op = 7'b0100011;
      d = $urandom_range(0, 9);
      if (d == 7) d = 15;
      else if (d >= 8) d = 16;
      else d = d % 5;
      run_instr(op, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                $urandom, $urandom, d, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
